dvsd_pe_arb: RTL and testbench

Parametrised, registered priority encoder and round-robin arbiter. It is the next generation of the project's 8-to-3 priority encoder and keeps that block's enable / group-select / enable-out semantics. It adds arbitrary width, a valid/ready handshake on both sides, one registered output stage and a rotating-priority mode. It sits inside the user project area, between the wishbone/LA-driven request source and the consumer of the encoded index.

---
 rtl/dvsd_pe_pkg.sv | 12 +
 rtl/dvsd_pe_core.sv | 40 ++++
 rtl/dvsd_pe_arb.sv | 92 +++++++++
 tb/tb_dvsd_pe_arb.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dvsd_pe_pkg.sv
// Shared types and limits for the dvsd_pe priority encoder / round-robin arbiter.
package dvsd_pe_pkg;

    typedef enum logic [0:0] {
        PE_FIXED = 1'b0,
        PE_RR    = 1'b1
    } pe_mode_e;

    localparam int PE_MIN_WIDTH = 2;
    localparam int PE_MAX_WIDTH = 64;

endpackage

// File: rtl/dvsd_pe_core.sv
// Combinational wrap-around priority search: walks downward from start, first set bit wins.
module dvsd_pe_core
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
)
(
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] start,
    input  logic             en,
    output logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] grant,
    output logic             gs,
    output logic             eno
);

    logic             found;
    logic [IDX_W-1:0] pos;

    always_comb begin
        idx   = '0;
        grant = '0;
        found = 1'b0;
        pos   = '0;
        if (en) begin
            for (int unsigned k = 0; k < WIDTH; k++) begin
                pos = IDX_W'((int'(start) + WIDTH - int'(k)) % WIDTH);
                if (!found && req[pos]) begin
                    found      = 1'b1;
                    idx        = pos;
                    grant[pos] = 1'b1;
                end
            end
        end
    end

    assign gs  = en && (|req);
    assign eno = en && !(|req);

endmodule

// File: rtl/dvsd_pe_arb.sv
// Registered priority encoder / round-robin arbiter with valid/ready on both sides.
// Round-robin pointer and rotation are built only when DVSD_PE_RR_EN is defined.
module dvsd_pe_arb
    import dvsd_pe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
)
(
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             en,
    input  logic [WIDTH-1:0] req,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] grant,
    output logic             gs,
    output logic             eno
);

    if (WIDTH < PE_MIN_WIDTH || WIDTH > PE_MAX_WIDTH) begin : g_bad_width
        $error("dvsd_pe_arb: WIDTH out of range");
    end

    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] c_idx;
    logic [WIDTH-1:0] c_grant;
    logic             c_gs;
    logic             c_eno;
    logic             accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef DVSD_PE_RR_EN
    logic [IDX_W-1:0] ptr;
    logic             rr;

    assign rr    = (pe_mode_e'(mode) == PE_RR);
    assign start = rr ? ptr : IDX_W'(WIDTH - 1);

    // Next search begins just below the last winner, so it gets lowest priority next time.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ptr <= IDX_W'(WIDTH - 1);
        end else if (accept && rr && c_gs) begin
            ptr <= (c_idx == '0) ? IDX_W'(WIDTH - 1) : c_idx - 1'b1;
        end
    end
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign start       = IDX_W'(WIDTH - 1);
`endif

    dvsd_pe_core #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_core (
        .req   (req),
        .start (start),
        .en    (en),
        .idx   (c_idx),
        .grant (c_grant),
        .gs    (c_gs),
        .eno   (c_eno)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            out_valid <= 1'b0;
            idx       <= '0;
            grant     <= '0;
            gs        <= 1'b0;
            eno       <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            idx       <= c_idx;
            grant     <= c_grant;
            gs        <= c_gs;
            eno       <= c_eno;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dvsd_pe_arb.sv
// Self-checking bench for dvsd_pe_arb (WIDTH=8) against a behavioural reference model.
module tb_dvsd_pe_arb;

    localparam int W = 8;
`ifdef DVSD_PE_RR_EN
    localparam bit RR_BUILD = 1'b1;
`else
    localparam bit RR_BUILD = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         en;
    logic [W-1:0] req;
    logic         mode;
    logic         in_valid;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   idx;
    logic [W-1:0] grant;
    logic         gs;
    logic         eno;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit       m_valid;
    int       m_idx;
    int       m_grant;
    bit       m_gs;
    bit       m_eno;
    int       m_ptr;

    dvsd_pe_arb #(.WIDTH(W)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .en        (en),
        .req       (req),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .idx       (idx),
        .grant     (grant),
        .gs        (gs),
        .eno       (eno)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int hi_bit(input int v);
        int r = -1;
        while (v != 0) begin
            v = v >> 1;
            r++;
        end
        return r;
    endfunction

    // Rotate so position p lands on the top bit, take the highest set bit, rotate back.
    function automatic int rr_winner(input int v, input int p);
        int s;
        int rot;
        s   = W - 1 - p;
        rot = ((v << s) | (v >> (W - s))) & 8'hFF;
        return (hi_bit(rot) - s + W) % W;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_idx = 0; m_grant = 0; m_gs = 0; m_eno = 0; m_ptr = W - 1;
    endtask

    task automatic check_outputs(input string tag);
        check($sformatf("%s.out_valid", tag), out_valid, m_valid);
        check($sformatf("%s.idx", tag), idx, m_idx);
        check($sformatf("%s.grant", tag), grant, m_grant);
        check($sformatf("%s.gs", tag), gs, m_gs);
        check($sformatf("%s.eno", tag), eno, m_eno);
    endtask

    // One clock of traffic: drive, check in_ready, advance model and DUT, check outputs.
    task automatic step(input logic e, input logic [W-1:0] r, input logic md,
                        input logic iv, input logic ordy, input string tag);
        bit acc;
        int w;
        en = e; req = r; mode = md; in_valid = iv; out_ready = ordy;
        #1;
        check($sformatf("%s.in_ready", tag), in_ready, (!m_valid || ordy));
        acc = iv && (!m_valid || ordy);
        if (acc) begin
            m_valid = 1;
            if (!e) begin
                m_idx = 0; m_grant = 0; m_gs = 0; m_eno = 0;
            end else if (r == 0) begin
                m_idx = 0; m_grant = 0; m_gs = 0; m_eno = 1;
            end else begin
                if (RR_BUILD && md) w = rr_winner(int'(r), m_ptr);
                else                w = hi_bit(int'(r));
                m_idx = w; m_grant = 1 << w; m_gs = 1; m_eno = 0;
                if (RR_BUILD && md) m_ptr = (w == 0) ? W - 1 : w - 1;
            end
        end else if (m_valid && ordy) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("reset_pulse");
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 0; req = '0; mode = 0; in_valid = 0; out_ready = 0;
        model_reset();
        #12;
        check_outputs("reset");
        check("reset.in_ready", in_ready, 1'b1);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        step(1, 8'b0010_0110, 0, 1, 1, "fixed");
        check("fixed.idx_const", idx, 3'd5);
        check("fixed.grant_const", grant, 8'h20);

        step(1, 8'h00, 0, 1, 1, "en1_req0");
        check("en1_req0.eno_const", eno, 1'b1);

        step(0, 8'hFF, 0, 1, 1, "en0");
        check("en0.valid_const", out_valid, 1'b1);
        check("en0.gs_const", gs, 1'b0);

        for (int i = 0; i < 9; i++) begin
            step(1, 8'hFF, 1, 1, 1, $sformatf("rr_seq%0d", i));
            check($sformatf("rr_seq%0d.idx_const", i), idx, RR_BUILD ? 3'((15 - i) % 8) : 3'd7);
        end

        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 8'b0000_1001, 1, 1, 1, $sformatf("rr_sparse%0d", i));
            check($sformatf("rr_sparse%0d.idx_const", i), idx,
                  (RR_BUILD && (i % 2 == 1)) ? 3'd0 : 3'd3);
        end

        step(1, 8'h08, 0, 1, 1, "bp_load");
        for (int i = 0; i < 4; i++) begin
            step(1, 8'h80, 0, 1, 0, $sformatf("bp_stall%0d", i));
            check($sformatf("bp_stall%0d.idx_const", i), idx, 3'd3);
        end
        step(1, 8'h80, 0, 1, 1, "bp_release");
        check("bp_release.idx_const", idx, 3'd7);
        step(1, 8'h00, 0, 0, 1, "drain");
        check("drain.valid_const", out_valid, 1'b0);

        step(1, 8'h08, 0, 1, 1, "ar_load");
        step(1, 8'h20, 0, 1, 0, "ar_stall");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_reset");
        check("async_reset.in_ready", in_ready, 1'b1);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        step(1, 8'hFF, 1, 1, 1, "post_reset_rr");
        check("post_reset_rr.idx_const", idx, 3'd7);

        for (int i = 0; i < 300; i++) begin
            logic       e;
            logic [7:0] r;
            e = ($urandom_range(0, 7) != 0);
            r = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            step(e, r, 1'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0), $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
